// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default datapath width, the canonical
// NOP encoding and the fetch-stage FSM state type.
package riscv_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: pc, instruction and valid bit.
// Flush has priority over enable; a flushed entry is invalid and carries a
// NOP. The pc field is left untouched on flush because it is meaningless
// once valid is low.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;

    // IF/ID storage: flush beats enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= {XLEN{1'b0}};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= valid_i;
        end else begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a synchronous instruction memory.
// The PC drives imem_addr; fetch_pc/fetch_valid tag the address whose data
// appears on imem_rdata this cycle. When a stall arrives while a valid fetch
// is in flight, the returning word is parked in a skid buffer (HOLD state)
// because the memory keeps reading the held PC and would otherwise lose it.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- force redirect targets
// to word alignment and pulse misalign_err when the target was misaligned.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    fetch_state_e    state_q,    state_d;
    logic [31:0]     skid_q,     skid_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target_s;
    logic            target_bad_s;
    logic            ifid_en_s;
    logic            ifid_flush_s;
    logic [31:0]     ifid_instr_s;

    // Redirect target conditioning (alignment fix-up when the check is built in).
    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        target_s     = {redirect_pc[XLEN-1:2], 2'b00};
        target_bad_s = |redirect_pc[1:0];
`else
        target_s     = redirect_pc;
        target_bad_s = 1'b0;
`endif
    end

    // Next-state logic: redirect beats stall beats sequential advance.
    always_comb begin
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        state_d       = state_q;
        skid_d        = skid_q;
        misalign_d    = 1'b0;
        ifid_en_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        ifid_instr_s  = NOP_INSTR;

        if (redirect) begin
            pc_d          = target_s;
            fetch_valid_d = 1'b0;
            state_d       = ST_RUN;
            skid_d        = NOP_INSTR;
            ifid_flush_s  = 1'b1;
            misalign_d    = target_bad_s;
        end else if (stall) begin
            case (state_q)
                ST_RUN: begin
                    if (fetch_valid_q) begin
                        state_d = ST_HOLD;
                        skid_d  = imem_rdata;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_RUN;
                    skid_d  = NOP_INSTR;
                end
            endcase
        end else begin
            pc_d          = pc_q + PC_STEP;
            fetch_pc_d    = pc_q;
            fetch_valid_d = 1'b1;
            state_d       = ST_RUN;
            skid_d        = NOP_INSTR;
            ifid_en_s     = 1'b1;
            if (!fetch_valid_q) begin
                ifid_instr_s = NOP_INSTR;
            end else if (state_q == ST_HOLD) begin
                ifid_instr_s = skid_q;
            end else begin
                ifid_instr_s = imem_rdata;
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fetch_pc_q    <= {XLEN{1'b0}};
            fetch_valid_q <= 1'b0;
            state_q       <= ST_RUN;
            skid_q        <= NOP_INSTR;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            state_q       <= state_d;
            skid_q        <= skid_d;
            misalign_q    <= misalign_d;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ifid_en_s),
        .flush_i (ifid_flush_s),
        .pc_i    (fetch_pc_q),
        .instr_i (ifid_instr_s),
        .valid_i (fetch_valid_q),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_addr  output  XLEN  fetch address to synchronous instruction memory; equals the PC register.
REQ-006 SHALL have port imem_rdata  input  32  instruction; valid one cycle after imem_addr is presented.
REQ-007 SHALL have port stall  input  1  hazard unit request to hold PC and IF/ID.
REQ-008 SHALL have port redirect  input  1  taken branch or jump from EX.
REQ-009 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-010 SHALL have ports if_id_pc  output  XLEN, if_id_instr  output  32, if_id_valid  output  1; registered IF/ID contents.
REQ-011 SHALL have port misalign_err  output  1  registered one-cycle pulse on a misaligned redirect.

Function
REQ-012 SHALL compute next PC with priority: redirect -> redirect_pc; else stall -> PC; else PC+4, modulo 2^XLEN (wrap at all-ones, no flag).
REQ-013 SHALL hold fetch_pc/fetch_valid registers tagging the address issued the previous cycle; fetch_valid<=0 on redirect, else <=1 unless stall holds it.
REQ-014 SHALL give 2-cycle latency from imem_addr presentation to the matching if_id_* update when unstalled.
REQ-015 SHALL implement FSM states RUN and HOLD: RUN->HOLD when stall=1, redirect=0, fetch_valid=1 (captures imem_rdata into skid buffer); HOLD->RUN when stall=0 or redirect=1.
REQ-016 SHALL, leaving HOLD with stall=0, load IF/ID from the skid buffer, not from imem_rdata.
REQ-017 SHALL, with stall=1 and redirect=0, hold if_id_pc, if_id_instr, if_id_valid unchanged.
REQ-018 SHALL, on redirect=1 (regardless of stall), flush: if_id_valid<=0, if_id_instr<=32'h0000_0013 (NOP), fetch_valid<=0, skid cleared, state<=RUN.
REQ-019 SHALL place the first redirect-target instruction in IF/ID with if_id_valid=1 two edges after the redirect edge, absent further stall.
REQ-020 SHALL load if_id_valid from fetch_valid on unstalled edges; invalid entries carry NOP.

Reset
REQ-021 SHALL on rst=1 set immediately PC=RESET_PC, fetch_pc=0, fetch_valid=0, state=RUN, skid=NOP, if_id_pc=0, if_id_instr=NOP, if_id_valid=0, misalign_err=0.
REQ-022 SHALL, when rst asserts mid-stall or mid-redirect, discard all in-flight and skid data; first valid IF/ID is mem[RESET_PC] two edges after rst deasserts.

Configuration
REQ-023 SHALL honour macro FETCH_MISALIGN_CHECK_EN: defined -> redirect with redirect_pc[1:0]!=0 loads PC with low two bits cleared and pulses misalign_err the following cycle.
REQ-024 SHALL, without FETCH_MISALIGN_CHECK_EN, load redirect_pc unmodified and tie misalign_err to 0.

Structure
REQ-025 SHALL take XLEN default, NOP constant (32'h0000_0013) and the fetch FSM state enum from shared package riscv_pkg.
REQ-026 SHALL implement IF/ID storage as sub-module if_id_reg (pc, instr, valid; enable and flush inputs, async reset).

Verification
REQ-027 SHALL cover reset release, RESET_PC=0x100, mem[0x100]=0xAAAA0001 -> if_id_pc=0x100, instr=0xAAAA0001, valid=1 at second edge after release; 0x104 next edge.
REQ-028 SHALL cover stall held 3 cycles while 0x108 in flight -> IF/ID frozen at 0x104; after release 0x108 from skid with correct instr, then 0x10C; no skip or duplicate.
REQ-029 SHALL cover redirect to 0x200 with stall=1 same cycle -> valid=0, instr=NOP next edge; 0x200 valid two edges after redirect.
REQ-030 SHALL cover PC=0xFFFF_FFFC unstalled -> imem_addr wraps to 0x0000_0000.
REQ-031 SHALL cover redirect_pc=0x203 with macro defined -> imem_addr=0x200, misalign_err=1 for one cycle; without macro imem_addr=0x203, misalign_err=0.
REQ-032 SHALL cover rst asserted in HOLD state -> outputs at reset values asynchronously; skid contents never reach IF/ID.
